// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray-coded twin, used as a CDC-safe pointer source.
// All outputs come straight from flops; load presets, WRAP selects modulo vs saturating behaviour.
module bin2gray_counter #(
    parameter int DATA_W = 32,
    parameter bit WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [DATA_W-1:0] load_bin,
    output logic [DATA_W-1:0] bin_q,
    output logic [DATA_W-1:0] gray_q,
    output logic              at_max,
    output logic              at_min,
    output logic              step
);

    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ALL_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W:0]   ONE_EXT  = {{DATA_W{1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] bin_to_gray(input logic [DATA_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_W-1:0] bin_r;
    logic [DATA_W-1:0] gray_r;
    logic              at_max_r;
    logic              at_min_r;
    logic              step_r;

    logic [DATA_W:0]   inc_s;
    logic [DATA_W:0]   dec_s;
    logic [DATA_W-1:0] bin_next_s;
    logic [DATA_W-1:0] gray_next_s;

    // One extra bit holds the carry/borrow, which doubles as the saturation detect
    assign inc_s = {1'b0, bin_r} + ONE_EXT;
    assign dec_s = {1'b0, bin_r} - ONE_EXT;

    // Next-count selection: load beats en; a dropped step is not deferred
    always_comb begin
        bin_next_s = bin_r;
        if (load) begin
            bin_next_s = load_bin;
        end else if (en) begin
            if (up) begin
                if (inc_s[DATA_W] && !WRAP) begin
                    bin_next_s = bin_r;
                end else begin
                    bin_next_s = inc_s[DATA_W-1:0];
                end
            end else begin
                if (dec_s[DATA_W] && !WRAP) begin
                    bin_next_s = bin_r;
                end else begin
                    bin_next_s = dec_s[DATA_W-1:0];
                end
            end
        end else begin
            bin_next_s = bin_r;
        end
        gray_next_s = bin_to_gray(bin_next_s);
    end

    // State and flag registers; Gray and flags are derived from bin_next_s so they never lag
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r    <= ALL_ZERO;
            gray_r   <= ALL_ZERO;
            at_max_r <= 1'b0;
            at_min_r <= 1'b1;
            step_r   <= 1'b0;
        end else begin
            bin_r    <= bin_next_s;
            gray_r   <= gray_next_s;
            at_max_r <= (bin_next_s == ALL_ONES);
            at_min_r <= (bin_next_s == ALL_ZERO);
            step_r   <= (gray_next_s != gray_r);
        end
    end

    assign bin_q  = bin_r;
    assign gray_q = gray_r;
    assign at_max = at_max_r;
    assign at_min = at_min_r;
    assign step   = step_r;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Self-checking bench: three counter variants (4-bit wrap, 4-bit saturate, 8-bit wrap) share stimulus
// and are compared every cycle against an integer-arithmetic model, plus literal directed checks.
module tb_bin2gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lb = 8'h00;

    logic [3:0] bin4, gray4, bin4s, gray4s;
    logic [7:0] bin8, gray8;
    logic       amax4, amin4, stp4, amax4s, amin4s, stp4s, amax8, amin8, stp8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bin2gray_counter #(.DATA_W(4), .WRAP(1'b1)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb[3:0]),
        .bin_q(bin4), .gray_q(gray4), .at_max(amax4), .at_min(amin4), .step(stp4));
    bin2gray_counter #(.DATA_W(4), .WRAP(1'b0)) dut4s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb[3:0]),
        .bin_q(bin4s), .gray_q(gray4s), .at_max(amax4s), .at_min(amin4s), .step(stp4s));
    bin2gray_counter #(.DATA_W(8), .WRAP(1'b1)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb),
        .bin_q(bin8), .gray_q(gray8), .at_max(amax8), .at_min(amin8), .step(stp8));

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nxt(input int w, input bit wrap, input int b, input bit r,
                               input bit l, input bit e, input bit u, input int lv);
        int mx;
        mx = (1 << w) - 1;
        if (r) return 0;
        if (l) return lv & mx;
        if (!e) return b;
        if (u) return (b == mx) ? (wrap ? 0 : mx) : b + 1;
        return (b == 0) ? (wrap ? mx : 0) : b - 1;
    endfunction

    function automatic int gry(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int ungray(input int g, input int w);
        int b;
        b = 0;
        for (int i = w - 1; i >= 0; i--) begin
            b |= (((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i;
        end
        return b;
    endfunction

    int  m4, m4s, m8;
    bit  ms4, ms4s, ms8;
    bit  valid = 1'b0;
    bit  counted = 1'b0;

    // Model update on the same edge as the DUTs
    always @(posedge clk) begin
        m4   <= nxt(4, 1'b1, m4, rst, load, en, up, int'(lb));
        m4s  <= nxt(4, 1'b0, m4s, rst, load, en, up, int'(lb));
        m8   <= nxt(8, 1'b1, m8, rst, load, en, up, int'(lb));
        ms4  <= !rst && (gry(nxt(4, 1'b1, m4, rst, load, en, up, int'(lb))) != gry(m4));
        ms4s <= !rst && (gry(nxt(4, 1'b0, m4s, rst, load, en, up, int'(lb))) != gry(m4s));
        ms8  <= !rst && (gry(nxt(8, 1'b1, m8, rst, load, en, up, int'(lb))) != gry(m8));
        counted <= !rst && !load && en;
        if (rst) valid <= 1'b1;
    end

    int prev_g8 = 0;

    // Compare all three DUTs against the model every cycle once reset has been seen
    always @(negedge clk) begin
        if (valid) begin
            chk("bin4", int'(bin4), m4);
            chk("gray4", int'(gray4), gry(m4));
            chk("step4", int'(stp4), int'(ms4));
            chk("max4", int'(amax4), int'(m4 == 15));
            chk("min4", int'(amin4), int'(m4 == 0));
            chk("bin4s", int'(bin4s), m4s);
            chk("gray4s", int'(gray4s), gry(m4s));
            chk("step4s", int'(stp4s), int'(ms4s));
            chk("max4s", int'(amax4s), int'(m4s == 15));
            chk("min4s", int'(amin4s), int'(m4s == 0));
            chk("bin8", int'(bin8), m8);
            chk("step8", int'(stp8), int'(ms8));
            chk("max8", int'(amax8), int'(m8 == 255));
            chk("min8", int'(amin8), int'(m8 == 0));
            chk("decode8", ungray(int'(gray8), 8), int'(bin8));
            if (counted && stp8) chk("onebit8", $countones(int'(gray8) ^ prev_g8), 1);
            prev_g8 = int'(gray8);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        // reset for two cycles
        rst = 1'b1; cyc(); cyc();
        chk("rst_bin", int'(bin4), 0);
        chk("rst_gray", int'(gray4), 0);
        chk("rst_min", int'(amin4), 1);
        chk("rst_max", int'(amax4), 0);
        chk("rst_step", int'(stp4), 0);

        // free-running up count with wrap
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("seq_gray4", int'(gray4), gseq[(i + 1) % 16]);
            chk("seq_step4", int'(stp4), 1);
        end

        // load then count down
        en = 1'b0; load = 1'b1; lb = 8'h0A; cyc();
        chk("ld_bin", int'(bin4), 10);
        chk("ld_gray", int'(gray4), 15);
        chk("ld_step", int'(stp4), 1);
        load = 1'b0; en = 1'b1; up = 1'b0; cyc();
        chk("dn_bin", int'(bin4), 9);
        chk("dn_gray", int'(gray4), 13);

        // saturation at both ends
        en = 1'b0; load = 1'b1; lb = 8'h0E; cyc();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sat_hi_bin", int'(bin4s), 15);
            chk("sat_hi_max", int'(amax4s), 1);
            chk("sat_hi_step", int'(stp4s), (i == 0) ? 1 : 0);
        end
        up = 1'b0;
        for (int i = 0; i < 18; i++) cyc();
        chk("sat_lo_bin", int'(bin4s), 0);
        chk("sat_lo_min", int'(amin4s), 1);
        chk("sat_lo_step", int'(stp4s), 0);

        // load beats en; reset beats load
        en = 1'b0; load = 1'b1; lb = 8'h02; cyc();
        en = 1'b1; up = 1'b1; lb = 8'h05; cyc();
        chk("ld_vs_en", int'(bin4), 5);
        rst = 1'b1; lb = 8'h07; cyc();
        chk("rst_vs_ld", int'(bin4), 0);
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; cyc();
        chk("resume", int'(bin4), 1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 2) != 0);
            lb   = 8'($urandom_range(0, 255));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
